// File: rtl/el2_lsu_bus_clken_gen.sv
// Core-to-bus clock qualifier: pulses lsu_bus_clk_en once per bus period for a
// programmable core:bus ratio, applying ratio updates only at period boundaries.
module el2_lsu_bus_clken_gen #(
    parameter int MAX_RATIO = 8,
    localparam int CNT_W = $clog2(MAX_RATIO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] lsu_bus_ratio_cfg,
    input  logic             lsu_bus_ratio_upd,
    output logic             lsu_bus_clk_en,
    output logic             lsu_bus_clk_en_next,
    output logic [CNT_W-1:0] lsu_bus_ratio_act,
    output logic             lsu_bus_ratio_pend,
    output logic [15:0]      lsu_bus_edge_cnt
);

    localparam logic [CNT_W-1:0] MAX_CODE = CNT_W'(MAX_RATIO - 1);

    // Requested codes beyond the largest supported divide saturate rather than alias.
    function automatic logic [CNT_W-1:0] clamp_cfg(input logic [CNT_W-1:0] cfg);
        logic [CNT_W-1:0] res;
        if (cfg > MAX_CODE) begin
            res = MAX_CODE;
        end else begin
            res = cfg;
        end
        return res;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] ratio_act_r;
    logic [CNT_W-1:0] ratio_pend_val_r;
    logic             pend_vld_r;
    logic             en_q_r;
    logic [15:0]      edge_cnt_r;
    logic             term_s;
    logic [CNT_W-1:0] cfg_in_s;

    // Period terminal detect and clamped request.
    always_comb begin
        term_s   = (cnt_r == ratio_act_r);
        cfg_in_s = clamp_cfg(lsu_bus_ratio_cfg);
    end

    // Phase counter, ratio hand-over at the boundary, and bus-edge accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r            <= '0;
            ratio_act_r      <= '0;
            ratio_pend_val_r <= '0;
            pend_vld_r       <= 1'b0;
            en_q_r           <= 1'b0;
            edge_cnt_r       <= 16'h0000;
        end else begin
            en_q_r     <= term_s;
            edge_cnt_r <= edge_cnt_r + {15'd0, en_q_r};
            if (term_s) begin
                cnt_r      <= '0;
                pend_vld_r <= 1'b0;
                if (lsu_bus_ratio_upd) begin
                    ratio_act_r <= cfg_in_s;
                end else if (pend_vld_r) begin
                    ratio_act_r <= ratio_pend_val_r;
                end else begin
                    ratio_act_r <= ratio_act_r;
                end
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
                if (lsu_bus_ratio_upd) begin
                    ratio_pend_val_r <= cfg_in_s;
                    pend_vld_r       <= 1'b1;
                end else begin
                    ratio_pend_val_r <= ratio_pend_val_r;
                    pend_vld_r       <= pend_vld_r;
                end
            end
        end
    end

    assign lsu_bus_clk_en      = en_q_r;
    assign lsu_bus_clk_en_next = term_s;
    assign lsu_bus_ratio_act   = ratio_act_r;
    assign lsu_bus_ratio_pend  = pend_vld_r;
    assign lsu_bus_edge_cnt    = edge_cnt_r;

endmodule

// File: tb/tb_el2_lsu_bus_clken_gen.sv
// Directed bench for el2_lsu_bus_clken_gen; a second instance with MAX_RATIO=6
// exercises the saturation of out-of-range ratio requests.
module tb_el2_lsu_bus_clken_gen;

    logic        clk;
    logic        rst;
    logic [2:0]  cfg;
    logic        upd;
    logic        en, en_next, pend;
    logic [2:0]  act;
    logic [15:0] ecnt;
    logic        c_en, c_next, c_pend;
    logic [2:0]  c_act;
    logic [15:0] c_ecnt;

    int checks = 0;
    int errors = 0;

    el2_lsu_bus_clken_gen #(.MAX_RATIO(8)) dut (
        .clk(clk), .rst(rst),
        .lsu_bus_ratio_cfg(cfg), .lsu_bus_ratio_upd(upd),
        .lsu_bus_clk_en(en), .lsu_bus_clk_en_next(en_next),
        .lsu_bus_ratio_act(act), .lsu_bus_ratio_pend(pend),
        .lsu_bus_edge_cnt(ecnt)
    );

    el2_lsu_bus_clken_gen #(.MAX_RATIO(6)) dut_clamp (
        .clk(clk), .rst(rst),
        .lsu_bus_ratio_cfg(cfg), .lsu_bus_ratio_upd(upd),
        .lsu_bus_clk_en(c_en), .lsu_bus_clk_en_next(c_next),
        .lsu_bus_ratio_act(c_act), .lsu_bus_ratio_pend(c_pend),
        .lsu_bus_edge_cnt(c_ecnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        upd = 1'b0;
        cfg = 3'd0;
        #1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        upd = 1'b0;
        cfg = 3'd0;
        #1;
        checks++;
        if (en !== 1'b0 || act !== 3'd0 || pend !== 1'b0 || ecnt !== 16'h0000 || en_next !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: en=%b act=%0d pend=%b ecnt=%h next=%b want 0 0 0 0000 1",
                     en, act, pend, ecnt, en_next);
        end
        checks++;
        if (c_en !== 1'b0 || c_act !== 3'd0 || c_pend !== 1'b0 || c_ecnt !== 16'h0000 || c_next !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs_clamp: en=%b act=%0d pend=%b ecnt=%h next=%b want 0 0 0 0000 1",
                     c_en, c_act, c_pend, c_ecnt, c_next);
        end
        repeat (5) tick();
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_en: en=%b want 0", en);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (en !== 1'b1 || ecnt !== 16'(i)) begin
                errors++;
                $display("FAIL ratio1_run[%0d]: en=%b ecnt=%0d want 1 %0d", i, en, ecnt, i);
            end
        end
    endtask

    task automatic test_direct_update();
        do_reset();
        tick();
        tick();
        cfg = 3'd3;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        checks++;
        if (act !== 3'd3 || en !== 1'b1 || pend !== 1'b0) begin
            errors++;
            $display("FAIL direct_apply: act=%0d en=%b pend=%b want 3 1 0", act, en, pend);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (en !== (i % 4 == 3) || pend !== 1'b0) begin
                errors++;
                $display("FAIL ratio4_pattern[%0d]: en=%b pend=%b want %b 0", i, en, pend, (i % 4 == 3));
            end
        end
    endtask

    task automatic test_pending_update();
        tick();
        cfg = 3'd1;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        checks++;
        if (pend !== 1'b1 || act !== 3'd3 || en !== 1'b0) begin
            errors++;
            $display("FAIL pend_capture: pend=%b act=%0d en=%b want 1 3 0", pend, act, en);
        end
        tick();
        checks++;
        if (en !== 1'b0 || en_next !== 1'b1) begin
            errors++;
            $display("FAIL pend_period_tail: en=%b next=%b want 0 1", en, en_next);
        end
        tick();
        checks++;
        if (en !== 1'b1 || act !== 3'd1 || pend !== 1'b0) begin
            errors++;
            $display("FAIL pend_boundary: en=%b act=%0d pend=%b want 1 1 0", en, act, pend);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (en !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL ratio2_pattern[%0d]: en=%b want %b", i, en, (i % 2 == 1));
            end
        end
    endtask

    task automatic test_last_wins();
        do_reset();
        cfg = 3'd3;
        upd = 1'b1;
        tick();
        cfg = 3'd2;
        tick();
        cfg = 3'd5;
        tick();
        upd = 1'b0;
        checks++;
        if (pend !== 1'b1 || act !== 3'd3) begin
            errors++;
            $display("FAIL last_wins_pending: pend=%b act=%0d want 1 3", pend, act);
        end
        tick();
        tick();
        checks++;
        if (en !== 1'b1 || act !== 3'd5 || pend !== 1'b0) begin
            errors++;
            $display("FAIL last_wins_apply: en=%b act=%0d pend=%b want 1 5 0", en, act, pend);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (en !== (i % 6 == 5)) begin
                errors++;
                $display("FAIL ratio6_pattern[%0d]: en=%b want %b", i, en, (i % 6 == 5));
            end
        end
    endtask

    task automatic test_max_ratio();
        do_reset();
        cfg = 3'd7;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        checks++;
        if (act !== 3'd7 || c_act !== 3'd5) begin
            errors++;
            $display("FAIL max_ratio_act: act=%0d clamp_act=%0d want 7 5", act, c_act);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (en !== (i % 8 == 7) || c_en !== (i % 6 == 5)) begin
                errors++;
                $display("FAIL max_ratio_pattern[%0d]: en=%b clamp_en=%b want %b %b",
                         i, en, c_en, (i % 8 == 7), (i % 6 == 5));
            end
        end
    endtask

    task automatic test_reset_midperiod();
        do_reset();
        cfg = 3'd3;
        upd = 1'b1;
        tick();
        cfg = 3'd1;
        tick();
        upd = 1'b0;
        tick();
        checks++;
        if (pend !== 1'b1 || act !== 3'd3 || en_next !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre_reset: pend=%b act=%0d next=%b want 1 3 0", pend, act, en_next);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (en !== 1'b0 || act !== 3'd0 || pend !== 1'b0 || ecnt !== 16'h0000 || en_next !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_reset: en=%b act=%0d pend=%b ecnt=%h next=%b want 0 0 0 0000 1",
                     en, act, pend, ecnt, en_next);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (en !== 1'b1 || act !== 3'd0 || pend !== 1'b0) begin
                errors++;
                $display("FAIL mid_restart[%0d]: en=%b act=%0d pend=%b want 1 0 0", i, en, act, pend);
            end
        end
    endtask

    task automatic test_edge_wrap();
        do_reset();
        tick();
        repeat (999) tick();
        checks++;
        if (ecnt !== 16'd999) begin
            errors++;
            $display("FAIL edge_cnt_mid: ecnt=%0d want 999", ecnt);
        end
        repeat (64536) tick();
        checks++;
        if (ecnt !== 16'hFFFF || en !== 1'b1) begin
            errors++;
            $display("FAIL edge_cnt_full: ecnt=%h en=%b want FFFF 1", ecnt, en);
        end
        tick();
        checks++;
        if (ecnt !== 16'h0000 || en !== 1'b1) begin
            errors++;
            $display("FAIL edge_cnt_wrap: ecnt=%h en=%b want 0000 1", ecnt, en);
        end
    endtask

    initial begin
        rst = 1'b1;
        upd = 1'b0;
        cfg = 3'd0;
        test_reset();
        test_direct_update();
        test_pending_update();
        test_last_wins();
        test_max_ratio();
        test_reset_midperiod();
        test_edge_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
